// File: rtl/pu_sequencer.sv
// pu_sequencer: walks every neuron of a layer, slices weight/input rows into
// 8-byte chunks for the 8-lane PU, sequences ld_mult/ld_add/acc and writes the
// PU ReLU output of each neuron into the result buffer.
module pu_sequencer #(
    parameter int N_IN     = 62,
    parameter int N_NEURON = 30,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*N_IN-1:0]   w_row,
    input  logic [8*N_IN-1:0]   x_row,
    input  logic [7:0]          b_in,
    input  logic [7:0]          pu_out,
    output logic [ADDR_W-1:0]   w_addr,
    output logic                mem_read,
    output logic [63:0]         x,
    output logic [63:0]         w,
    output logic [7:0]          bias,
    output logic                ld_mult,
    output logic                ld_add,
    output logic                acc,
    output logic                result_we,
    output logic [ADDR_W-1:0]   result_addr,
    output logic [7:0]          result_data,
    output logic                busy,
    output logic                done
);
    localparam int NCHUNK = (N_IN + 7) / 8;
    localparam int ROW_W  = 8 * N_IN;
    localparam int PAD_W  = 64 * NCHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_neuron, w_neuron_nxt;
    logic [CW-1:0]       r_chunk, w_chunk_nxt;
    logic [ROW_W-1:0]    r_wrow, r_xrow;

    logic [ADDR_W-1:0]   r_w_addr, r_result_addr;
    logic                r_mem_read, r_ld_mult, r_ld_add, r_acc;
    logic                r_result_we, r_busy, r_done;
    logic [63:0]         r_x, r_w;
    logic [7:0]          r_bias, r_result_data;

    logic                w_ld_add_nxt, w_acc_nxt;
    logic [PAD_W-1:0]    w_xpad, w_wpad, w_xsh, w_wsh;
    logic [CW+5:0]       w_shamt;

    // Chunk 0 goes out on the same edge the rows are latched, so it is taken
    // from the memory inputs while in FETCH; later chunks use the latches.
    // Rows are left-aligned into a 64-bit multiple so the tail is zero-padded.
    assign w_xpad  = PAD_W'(r_state == S_FETCH ? x_row : r_xrow) << (PAD_W - ROW_W);
    assign w_wpad  = PAD_W'(r_state == S_FETCH ? w_row : r_wrow) << (PAD_W - ROW_W);
    assign w_shamt = {w_chunk_nxt, 6'b0};
    assign w_xsh   = w_xpad << w_shamt;
    assign w_wsh   = w_wpad << w_shamt;

    // Next-state and next control values; outputs are registered from these
    // so PU controls line up with the state they belong to.
    always_comb begin
        w_state_nxt  = r_state;
        w_neuron_nxt = r_neuron;
        w_chunk_nxt  = r_chunk;
        case (r_state)
            S_IDLE: if (start) begin
                w_state_nxt  = S_FETCH;
                w_neuron_nxt = '0;
            end
            S_FETCH: begin
                w_state_nxt = S_RUN;
                w_chunk_nxt = '0;
            end
            S_RUN: begin
                if (r_chunk == CW'(NCHUNK - 1)) w_state_nxt = S_DRAIN;
                else                            w_chunk_nxt = r_chunk + CW'(1);
            end
            S_DRAIN: w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (r_neuron == ADDR_W'(N_NEURON - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt  = S_FETCH;
                    w_neuron_nxt = r_neuron + ADDR_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_ld_add_nxt = ((w_state_nxt == S_RUN) && (w_chunk_nxt != '0)) || (w_state_nxt == S_DRAIN);
        w_acc_nxt    = ((w_state_nxt == S_RUN) && (w_chunk_nxt > CW'(1)))
                     || ((w_state_nxt == S_DRAIN) && (NCHUNK >= 2));
    end

    // State, counters, row/bias latches and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_neuron      <= '0;
            r_chunk       <= '0;
            r_wrow        <= '0;
            r_xrow        <= '0;
            r_w_addr      <= '0;
            r_mem_read    <= 1'b0;
            r_x           <= '0;
            r_w           <= '0;
            r_bias        <= '0;
            r_ld_mult     <= 1'b0;
            r_ld_add      <= 1'b0;
            r_acc         <= 1'b0;
            r_result_we   <= 1'b0;
            r_result_addr <= '0;
            r_result_data <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_neuron   <= w_neuron_nxt;
            r_chunk    <= w_chunk_nxt;
            r_mem_read <= (w_state_nxt == S_FETCH);
            if (w_state_nxt == S_FETCH) r_w_addr <= w_neuron_nxt;
            if (r_state == S_FETCH) begin
                r_wrow <= w_row;
                r_xrow <= x_row;
                r_bias <= b_in;
            end
            r_ld_mult <= (w_state_nxt == S_RUN);
            r_ld_add  <= w_ld_add_nxt;
            r_acc     <= w_acc_nxt;
            r_x       <= (w_state_nxt == S_RUN) ? w_xsh[PAD_W-1 -: 64] : 64'h0;
            r_w       <= (w_state_nxt == S_RUN) ? w_wsh[PAD_W-1 -: 64] : 64'h0;
            // Accumulator settles at the end of DRAIN, so pu_out is captured
            // at the end of WRITE and presented with the strobe next cycle.
            r_result_we <= (r_state == S_WRITE);
            if (r_state == S_WRITE) begin
                r_result_addr <= r_neuron;
                r_result_data <= pu_out;
            end
            r_done <= (r_state == S_DONE);
            if (r_state == S_IDLE && start) r_busy <= 1'b1;
            else if (r_state == S_DONE)     r_busy <= 1'b0;
        end
    end

    assign w_addr      = r_w_addr;
    assign mem_read    = r_mem_read;
    assign x           = r_x;
    assign w           = r_w;
    assign bias        = r_bias;
    assign ld_mult     = r_ld_mult;
    assign ld_add      = r_ld_add;
    assign acc         = r_acc;
    assign result_we   = r_result_we;
    assign result_addr = r_result_addr;
    assign result_data = r_result_data;
    assign busy        = r_busy;
    assign done        = r_done;
endmodule

// File: tb/tb_pu_sequencer.sv
// Directed bench for pu_sequencer: per-phase control table, chunk slicing,
// behavioural PU results, start-while-busy and mid-pass reset.
module tb_pu_sequencer;
    localparam int N_IN  = 62;
    localparam int NN    = 30;
    localparam int ROW_W = 8 * N_IN;

    logic              clk = 1'b0;
    logic              rst, start;
    logic [ROW_W-1:0]  w_row, x_row;
    logic [7:0]        b_in, pu_out;
    logic [4:0]        w_addr, result_addr;
    logic              mem_read, ld_mult, ld_add, acc, result_we, busy, done;
    logic [63:0]       x, w;
    logic [7:0]        bias, result_data;

    int  ntests = 0;
    int  nfail  = 0;
    bit  modeB  = 1'b0;

    pu_sequencer #(.N_IN(N_IN), .N_NEURON(NN), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .w_row(w_row), .x_row(x_row),
        .b_in(b_in), .pu_out(pu_out), .w_addr(w_addr), .mem_read(mem_read),
        .x(x), .w(w), .bias(bias), .ld_mult(ld_mult), .ld_add(ld_add),
        .acc(acc), .result_we(result_we), .result_addr(result_addr),
        .result_data(result_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memories: valid rows only while mem_read is high, all-ones junk otherwise.
    always_comb begin
        x_row = '1;
        w_row = '1;
        b_in  = 8'hFF;
        if (mem_read) begin
            b_in = {3'b0, w_addr};
            for (int k = 0; k < N_IN; k++) begin
                x_row[ROW_W-1-8*k -: 8] = modeB ? 8'(k) : 8'h01;
                w_row[ROW_W-1-8*k -: 8] = 8'h01;
            end
        end
    end

    // Behavioural PU: 8-lane dot product register, accumulator, bias + ReLU (saturating).
    logic [19:0] pm   = '0;
    logic [23:0] pacc = '0;
    logic [23:0] psum;
    always @(posedge clk) begin
        logic [19:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s = s + 20'(x[8*i +: 8]) * 20'(w[8*i +: 8]);
        if (ld_mult) pm <= s;
        if (ld_add)  pacc <= acc ? pacc + 24'(pm) : 24'(pm);
    end
    assign psum   = pacc + 24'(bias);
    assign pu_out = (psum > 24'd255) ? 8'hFF : psum[7:0];

    typedef struct {
        int   phase;
        logic mr, lm, la, ac;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One layer pass starting from IDLE; k counts negedge samples after the
    // start-accepting edge. Returns early at abort_k (>=0) for reset tests.
    task automatic run_pass(input bit mb, input bit hold, input int abort_k);
        int nmr, nwe, n, p, c, np;
        logic [6:0] act_c, exp_c;
        logic [63:0] ex;
        nmr = 0; nwe = 0;
        modeB = mb;
        start = 1'b1;
        @(posedge clk);
        #1 if (!hold) start = 1'b0;
        for (int k = 0; k <= 335; k++) begin
            @(negedge clk);
            if (k == abort_k) return;
            if (hold && k == 200) start = 1'b0;
            if (hold && k == 250) start = 1'b1;
            if (hold && k == 251) start = 1'b0;
            n = k / 11; p = k % 11;
            if (mem_read)  nmr++;
            if (result_we) nwe++;
            act_c = {mem_read, ld_mult, ld_add, acc, result_we, done, busy};
            if (k < 330)       exp_c = {tbl[p].mr, tbl[p].lm, tbl[p].la, tbl[p].ac, (p == 0 && k >= 11), 1'b0, 1'b1};
            else if (k == 330) exp_c = 7'b0000101;
            else if (k == 331) exp_c = 7'b0000010;
            else               exp_c = 7'b0000000;
            chk($sformatf("ctrl k=%0d", k), 64'(act_c), 64'(exp_c));
            if (exp_c[2]) begin
                np = n - 1;
                chk($sformatf("result_addr k=%0d", k), 64'(result_addr), 64'(np));
                chk($sformatf("result_data k=%0d", k), 64'(result_data), mb ? 64'd255 : 64'(62 + np));
            end
            if (k < 330) begin
                chk($sformatf("w_addr k=%0d", k), 64'(w_addr), 64'(n));
                if (p >= 1) chk($sformatf("bias k=%0d", k), 64'(bias), 64'(n));
            end
            if (k < 330 && p >= 1 && p <= 8) begin
                c = p - 1;
                chk($sformatf("w chunk n=%0d c=%0d", n, c), w,
                    (c == 7) ? 64'h0101010101010000 : 64'h0101010101010101);
                if (!mb) begin
                    ex = (c == 7) ? 64'h0101010101010000 : 64'h0101010101010101;
                    chk($sformatf("x chunk n=%0d c=%0d", n, c), x, ex);
                end else if (n == 0 && c == 0) begin
                    chk("x slice chunk0", x, 64'h0001020304050607);
                end else if (n == 0 && c == 7) begin
                    chk("x slice chunk7", x, 64'h38393A3B3C3D0000);
                end
            end
        end
        chk("mem_read count", 64'(nmr), 64'd30);
        chk("result_we count", 64'(nwe), 64'd30);
    endtask

    initial begin
        tbl[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{2,  1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 3; i <= 8; i++) tbl[i] = '{i, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{9,  1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{10, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ctrl", 64'({mem_read, ld_mult, ld_add, acc, result_we, done, busy}), 64'd0);
        chk("reset data", 64'({x | w, bias, w_addr, result_addr, result_data} != '0), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Pass 1: all-ones rows, start held high then re-pulsed while busy.
        run_pass(1'b0, 1'b1, -1);

        // Pass 2: ramp input row for slicing, reset during RUN of neuron 5.
        run_pass(1'b1, 1'b0, 5 * 11 + 3);
        rst = 1'b0;
        #1;
        chk("midreset ctrl", 64'({mem_read, ld_mult, ld_add, acc, result_we, done, busy}), 64'd0);
        chk("midreset data", 64'({x | w, bias, w_addr, result_addr, result_data} != '0), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle after reset %0d", i), 64'({mem_read, ld_mult, busy, result_we}), 64'd0);
        end

        // Pass 3: fresh pass must restart at neuron 0 and complete.
        run_pass(1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
